// File: rtl/dot_product_stream_engine_if.sv
// Beat/result handshake bundle for dot_product_stream_engine.
// The engine connects via the slave modport; the feeding/consuming side uses master.
interface dot_product_stream_engine_if #(
  parameter int DATA_W = 5,
  parameter int LANES  = 8,
  parameter int ACC_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_weight  [LANES-1:0];
  logic [DATA_W-1:0] in_feature [LANES-1:0];
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  partial_product;

  modport master (
    output flush, in_valid, in_weight, in_feature, out_ready,
    input  in_ready, out_valid, partial_product
  );

  modport slave (
    input  flush, in_valid, in_weight, in_feature, out_ready,
    output in_ready, out_valid, partial_product
  );
endinterface

// File: rtl/dot_product_stream_engine.sv
// Streaming dot product: LANES multiplies per beat, registered lane sum, accumulate over BEATS.
// Optional macro DOT_SAT_EN: saturating accumulation instead of modulo-2^ACC_W wrap.
module dot_product_stream_engine #(
  parameter int DATA_W  = 5,
  parameter int VEC_LEN = 96,
  parameter int LANES   = 8,
  parameter int ACC_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dot_product_stream_engine_if.slave bus
);
  localparam int BEATS  = VEC_LEN / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  if ((VEC_LEN % LANES) != 0) begin : g_len_check
    $error("VEC_LEN must be a multiple of LANES");
  end

  logic [CNT_W-1:0] beat_cnt;
  logic             p_valid;
  logic             p_first;
  logic             p_last;
  logic [SUM_W-1:0] p_sum;
  logic [ACC_W-1:0] acc;

  logic             hold;
  logic             accept;
  logic [SUM_W-1:0] lane_sum;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;

  // Ready depends only on registered state and the consumer, never on in_valid.
  assign hold         = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !hold;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + SUM_W'(PROD_W'(bus.in_weight[l]) * PROD_W'(bus.in_feature[l]));
    end
  end

  assign acc_base = p_first ? '0 : acc;

`ifdef DOT_SAT_EN
  logic [ACC_W:0] acc_sum;
  always_comb begin
    acc_sum  = (ACC_W+1)'(acc_base) + (ACC_W+1)'(p_sum);
    acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_next = acc_base + ACC_W'(p_sum);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt            <= '0;
      p_valid             <= 1'b0;
      p_first             <= 1'b0;
      p_last              <= 1'b0;
      p_sum               <= '0;
      acc                 <= '0;
      bus.out_valid       <= 1'b0;
      bus.partial_product <= '0;
    end else if (bus.flush) begin
      // Abort the vector in flight; an already completed result still waits for its handshake.
      beat_cnt <= '0;
      p_valid  <= 1'b0;
      acc      <= '0;
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end else if (!hold) begin
      if (accept) begin
        p_valid  <= 1'b1;
        p_sum    <= lane_sum;
        p_first  <= (beat_cnt == '0);
        p_last   <= (beat_cnt == CNT_W'(BEATS-1));
        beat_cnt <= (beat_cnt == CNT_W'(BEATS-1)) ? '0 : beat_cnt + 1'b1;
      end else begin
        p_valid <= 1'b0;
      end

      if (p_valid) begin
        acc <= acc_next;
      end

      if (p_valid && p_last) begin
        bus.out_valid       <= 1'b1;
        bus.partial_product <= acc_next;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dot_product_stream_engine.sv
// Directed self-checking bench for dot_product_stream_engine (default and LANES=1 instances).
module tb_dot_product_stream_engine;
  localparam int DATA_W  = 5;
  localparam int VEC_LEN = 96;
  localparam int LANES   = 8;
  localparam int ACC_W   = 16;
  localparam int BEATS   = VEC_LEN / LANES;

  localparam int K_RAMP  = 0;
  localparam int K_ALL31 = 1;
  localparam int K_ONES  = 2;
  localparam int K_W1F2  = 3;

`ifdef DOT_SAT_EN
  localparam logic [ACC_W-1:0] EXP_OVF = 16'd65535;
`else
  localparam logic [ACC_W-1:0] EXP_OVF = 16'd26720;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_product_stream_engine_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W)) ifc ();
  dot_product_stream_engine_if #(.DATA_W(DATA_W), .LANES(1), .ACC_W(ACC_W)) ifc_s ();

  dot_product_stream_engine #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  dot_product_stream_engine #(.DATA_W(DATA_W), .VEC_LEN(4), .LANES(1), .ACC_W(ACC_W)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc_s)
  );

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] results[$];

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) results.push_back(ifc.partial_product);
  end

  function automatic logic [DATA_W-1:0] elem(input int kind, input int i, input bit is_w);
    case (kind)
      K_RAMP:  return is_w ? DATA_W'(i % 32) : DATA_W'((i + 1) % 32);
      K_ALL31: return 5'd31;
      K_ONES:  return 5'd1;
      default: return is_w ? 5'd1 : 5'd2;
    endcase
  endfunction

  task automatic send_beat(input int kind, input int b);
    int  n;
    bit  done;
    for (int l = 0; l < LANES; l++) begin
      ifc.in_weight[l]  = elem(kind, b * LANES + l, 1'b1);
      ifc.in_feature[l] = elem(kind, b * LANES + l, 1'b0);
    end
    ifc.in_valid = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout beat %0d: in_ready stayed 0, required 1", b);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_vector(input int kind, input int nbeats);
    for (int b = 0; b < nbeats; b++) send_beat(kind, b);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int c = 0;
    while (results.size() < n && c < 60) begin
      @(posedge clk);
      c++;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.partial_product !== 16'd0) begin errors++; $display("FAIL reset_pp: got %0d want 0", ifc.partial_product); end
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    checks++; if (ifc_s.out_valid !== 1'b0) begin errors++; $display("FAIL reset_s_out_valid: got %b want 0", ifc_s.out_valid); end
    checks++; if (ifc_s.in_ready !== 1'b1) begin errors++; $display("FAIL reset_s_in_ready: got %b want 1", ifc_s.in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    results.delete();
    ifc.out_ready = 1'b1;
    send_vector(K_RAMP, BEATS);
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL ramp_latency_early: out_valid got %b want 0", ifc.out_valid); end
    @(posedge clk); #1;
    checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL ramp_latency: out_valid got %b want 1", ifc.out_valid); end
    checks++; if (ifc.partial_product !== 16'd29760) begin errors++; $display("FAIL ramp_value: got %0d want 29760", ifc.partial_product); end
    @(posedge clk); #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL ramp_drop: out_valid got %b want 0", ifc.out_valid); end
  endtask

  task automatic test_overflow();
    results.delete();
    send_vector(K_ALL31, BEATS);
    wait_results(1);
    checks++; if (results.size() !== 1) begin errors++; $display("FAIL ovf_count: got %0d want 1", results.size()); end
    else begin
      checks++; if (results[0] !== EXP_OVF) begin errors++; $display("FAIL ovf_value: got %0d want %0d", results[0], EXP_OVF); end
    end
  endtask

  task automatic test_back_to_back();
    results.delete();
    ifc.out_ready = 1'b0;
    fork
      begin
        send_vector(K_RAMP, BEATS);
        send_vector(K_W1F2, BEATS);
      end
      begin
        int n = 0;
        while (!ifc.out_valid && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid: got %b want 1", ifc.out_valid); end
        checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready: got %b want 0", ifc.in_ready); end
        checks++; if (ifc.partial_product !== 16'd29760) begin errors++; $display("FAIL b2b_hold_value: got %0d want 29760", ifc.partial_product); end
        repeat (4) @(negedge clk);
        checks++; if (ifc.partial_product !== 16'd29760) begin errors++; $display("FAIL b2b_stable: got %0d want 29760", ifc.partial_product); end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
      end
    join
    wait_results(2);
    checks++; if (results.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", results.size()); end
    else begin
      checks++; if (results[0] !== 16'd29760) begin errors++; $display("FAIL b2b_first: got %0d want 29760", results[0]); end
      checks++; if (results[1] !== 16'd192) begin errors++; $display("FAIL b2b_second: got %0d want 192", results[1]); end
    end
  endtask

  task automatic test_flush();
    results.delete();
    ifc.out_ready = 1'b1;
    send_vector(K_RAMP, 5);
    for (int l = 0; l < LANES; l++) begin
      ifc.in_weight[l]  = 5'd7;
      ifc.in_feature[l] = 5'd7;
    end
    ifc.in_valid = 1'b1;
    ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    send_vector(K_ONES, BEATS);
    wait_results(1);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (results.size() !== 1) begin errors++; $display("FAIL flush_count: got %0d want 1", results.size()); end
    else begin
      checks++; if (results[0] !== 16'd96) begin errors++; $display("FAIL flush_value: got %0d want 96", results[0]); end
    end
  endtask

  task automatic test_reset_mid();
    send_vector(K_RAMP, 7);
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.partial_product !== 16'd0) begin errors++; $display("FAIL rstmid_pp: got %0d want 0", ifc.partial_product); end
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", ifc.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    results.delete();
    send_vector(K_RAMP, BEATS);
    wait_results(1);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (results.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", results.size()); end
    else begin
      checks++; if (results[0] !== 16'd29760) begin errors++; $display("FAIL rstmid_value: got %0d want 29760", results[0]); end
    end
  endtask

  task automatic test_lanes1();
    ifc_s.out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      int n = 0;
      ifc_s.in_weight[0]  = DATA_W'(b + 1);
      ifc_s.in_feature[0] = DATA_W'(b + 5);
      ifc_s.in_valid = 1'b1;
      @(negedge clk);
      while (!ifc_s.in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin checks++; errors++; $display("FAIL lanes1_accept_timeout: in_ready 0, required 1"); end
      @(posedge clk); #1;
    end
    ifc_s.in_valid = 1'b0;
    checks++; if (ifc_s.out_valid !== 1'b0) begin errors++; $display("FAIL lanes1_latency_early: got %b want 0", ifc_s.out_valid); end
    @(posedge clk); #1;
    checks++; if (ifc_s.out_valid !== 1'b1) begin errors++; $display("FAIL lanes1_latency: got %b want 1", ifc_s.out_valid); end
    checks++; if (ifc_s.partial_product !== 16'd70) begin errors++; $display("FAIL lanes1_value: got %0d want 70", ifc_s.partial_product); end
  endtask

  initial begin
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    ifc_s.flush = 1'b0;
    ifc_s.in_valid = 1'b0;
    ifc_s.out_ready = 1'b0;
    ifc_s.in_weight[0] = '0;
    ifc_s.in_feature[0] = '0;
    for (int l = 0; l < LANES; l++) begin
      ifc.in_weight[l] = '0;
      ifc.in_feature[l] = '0;
    end
    test_reset();
    test_ramp();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_lanes1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
